// File: rtl/ds_160_align.sv
// Oversampling serial-to-parallel deserializer: samples one phase per OSR clocks,
// hunts for a sync word, then emits LSB-first words over a valid/ready handshake.
module ds_160_align #(
    parameter int               WIDTH        = 8,
    parameter int               OSR          = 4,
    parameter int               SAMPLE_PHASE = 3,
    parameter logic [WIDTH-1:0] SYNC_WORD    = 8'hBC,
    parameter bit               SYNC_CHECK   = 1'b1
) (
    input  logic             clock_160,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    input  logic             realign,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic             overflow
);
    localparam int PW = $clog2(OSR);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;
    localparam state_t RESET_STATE = SYNC_CHECK ? ST_HUNT : ST_LOCKED;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;

    logic             sample;
    logic             word_done;
    logic [WIDTH-1:0] cand;

    assign sample    = enable && (phase_q == PW'(SAMPLE_PHASE));
    assign cand      = {data_in, shifter_q[WIDTH-1:1]};
    assign word_done = (state_q == ST_LOCKED) && sample && (bitcnt_q == BW'(WIDTH - 1));

    // State register
    always_ff @(posedge clock_160) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; realign overrides a simultaneous sync match
    always_comb begin
        state_d = state_q;
        if (realign) begin
            state_d = SYNC_CHECK ? ST_HUNT : ST_LOCKED;
        end else if (state_q == ST_HUNT && sample && cand == SYNC_WORD) begin
            state_d = ST_LOCKED;
        end
    end

    // FSM outputs
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    always_comb begin
        phase_d      = phase_q;
        shifter_d    = shifter_q;
        bitcnt_d     = bitcnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overflow_d   = overflow_q;

        if (enable) begin
            phase_d = (phase_q == PW'(OSR - 1)) ? '0 : phase_q + PW'(1);
        end
        if (sample) begin
            shifter_d = cand;
        end

        // Bit counter only runs while locked; hunting keeps it at the boundary
        if (realign || state_q == ST_HUNT) begin
            bitcnt_d = '0;
        end else if (sample) begin
            bitcnt_d = word_done ? '0 : bitcnt_q + BW'(1);
        end

        if (word_done) begin
            data_out_d   = cand;
            data_valid_d = 1'b1;
            if (data_valid_q && !data_ready) begin
                overflow_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_160) begin
        if (reset) begin
            phase_q      <= '0;
            shifter_q    <= '0;
            bitcnt_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            shifter_q    <= shifter_d;
            bitcnt_q     <= bitcnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ds_160_align.sv
// Directed bench for ds_160_align: vector table for streaming/handshake, hand
// sequences for enable freeze, realign, and mid-word reset.
module tb_ds_160_align;
    logic       clock_160 = 1'b0;
    logic       reset, enable, data_in, realign, data_ready;
    logic [7:0] data_out, data_out_nl;
    logic       data_valid, locked, overflow;
    logic       data_valid_nl, locked_nl, overflow_nl;

    int n_cmp = 0;
    int n_bad = 0;

    always #3 clock_160 = ~clock_160;

    ds_160_align u_dut (
        .clock_160 (clock_160),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .realign   (realign),
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .locked    (locked),
        .overflow  (overflow)
    );

    // Instance that locks straight out of reset
    ds_160_align #(.SYNC_CHECK(1'b0)) u_dut_nl (
        .clock_160 (clock_160),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .realign   (realign),
        .data_ready(data_ready),
        .data_out  (data_out_nl),
        .data_valid(data_valid_nl),
        .locked    (locked_nl),
        .overflow  (overflow_nl)
    );

    typedef struct {
        logic [7:0] word;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_locked;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic tick;
        @(posedge clock_160);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            data_in = w[i];
            repeat (4) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] w);
        send_bits(w, 0, 7);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; data_in = 1'b0; realign = 1'b0; data_ready = 1'b1;

        tbl[0] = '{8'hBC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
        tbl[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[4] = '{8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};

        // T1: reset state
        do_reset();
        check8("rst_data", data_out, 8'h00);
        check1("rst_valid", data_valid, 1'b0);
        check1("rst_locked", locked, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        check1("rst_locked_nosync", locked_nl, 1'b1);
        $display("T1 reset: data=%02h valid=%0b locked=%0b ovf=%0b", data_out, data_valid, locked, overflow);

        // T2/T3: streaming table, sync lock then words with and without backpressure
        for (int v = 0; v < 6; v++) begin
            data_ready = tbl[v].ready;
            send_byte(tbl[v].word);
            check1($sformatf("vec%0d_valid", v), data_valid, tbl[v].exp_valid);
            if (tbl[v].exp_valid) check8($sformatf("vec%0d_data", v), data_out, tbl[v].exp_data);
            check1($sformatf("vec%0d_locked", v), locked, tbl[v].exp_locked);
            check1($sformatf("vec%0d_ovf", v), overflow, tbl[v].exp_ovf);
            $display("vec %0d word=%02h ready=%0b valid=%0b data=%02h locked=%0b ovf=%0b",
                     v, tbl[v].word, tbl[v].ready, data_valid, data_out, locked, overflow);
        end
        data_ready = 1'b1;
        tick();
        check1("t3_consume_valid", data_valid, 1'b0);
        check1("t3_ovf_sticky", overflow, 1'b1);
        $display("T3 consume: valid=%0b ovf=%0b", data_valid, overflow);

        // Ready on the completion edge of a new word: reload, no overflow
        do_reset();
        data_ready = 1'b0;
        send_byte(8'hBC);
        send_byte(8'h5A);
        check8("hs_first_data", data_out, 8'h5A);
        send_bits(8'h3C, 0, 6);
        data_in = 1'b0;
        repeat (3) tick();
        data_ready = 1'b1;
        tick();
        check1("hs_same_edge_valid", data_valid, 1'b1);
        check8("hs_same_edge_data", data_out, 8'h3C);
        check1("hs_same_edge_ovf", overflow, 1'b0);
        tick();
        check1("hs_drain_valid", data_valid, 1'b0);
        $display("handshake same-edge: data=%02h ovf=%0b", data_out, overflow);

        // T4: enable freeze mid-word
        do_reset();
        data_ready = 1'b1;
        send_byte(8'hBC);
        send_bits(8'h5A, 0, 3);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in = ~data_in;
            tick();
        end
        check1("t4_frozen_valid", data_valid, 1'b0);
        check1("t4_frozen_locked", locked, 1'b1);
        enable = 1'b1;
        send_bits(8'h5A, 4, 6);
        data_in = 1'b0;
        repeat (3) tick();
        check1("t4_early_valid", data_valid, 1'b0);
        tick();
        check1("t4_valid", data_valid, 1'b1);
        check8("t4_data", data_out, 8'h5A);
        $display("T4 enable freeze: data=%02h valid=%0b", data_out, data_valid);

        // T5: realign mid-word, hunt, relock
        do_reset();
        data_ready = 1'b1;
        send_byte(8'hBC);
        send_bits(8'h5A, 0, 3);
        data_in = 1'b1;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check1("t5_unlocked", locked, 1'b0);
        check1("t5_nosync_relocked", locked_nl, 1'b1);
        repeat (3) tick();
        send_bits(8'h5A, 5, 7);
        send_byte(8'hA5);
        check1("t5_hunt_locked", locked, 1'b0);
        check1("t5_hunt_valid", data_valid, 1'b0);
        send_byte(8'hBC);
        check1("t5_relock", locked, 1'b1);
        check1("t5_sync_not_out", data_valid, 1'b0);
        send_byte(8'h3C);
        check1("t5_valid", data_valid, 1'b1);
        check8("t5_data", data_out, 8'h3C);
        $display("T5 realign: locked=%0b data=%02h valid=%0b", locked, data_out, data_valid);

        // Realign on the completion edge: word still delivered, then hunt
        do_reset();
        data_ready = 1'b0;
        send_byte(8'hBC);
        send_bits(8'h66, 0, 6);
        data_in = 1'b0;
        repeat (3) tick();
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check1("ra_done_valid", data_valid, 1'b1);
        check8("ra_done_data", data_out, 8'h66);
        check1("ra_done_locked", locked, 1'b0);
        $display("realign+complete: data=%02h valid=%0b locked=%0b", data_out, data_valid, locked);

        // T6: reset mid-word
        do_reset();
        data_ready = 1'b1;
        send_byte(8'hBC);
        send_bits(8'h5A, 0, 4);
        do_reset();
        check1("t6_rst_valid", data_valid, 1'b0);
        check1("t6_rst_locked", locked, 1'b0);
        send_byte(8'hBC);
        check1("t6_sync_valid", data_valid, 1'b0);
        send_byte(8'h77);
        check1("t6_valid", data_valid, 1'b1);
        check8("t6_data", data_out, 8'h77);
        check1("t6_ovf", overflow, 1'b0);
        $display("T6 reset mid-word: data=%02h valid=%0b ovf=%0b", data_out, data_valid, overflow);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
